// File: rtl/traffic_pkg.sv
// Shared constants for the two-road phase scheduler:
// state encodings, lamp vectors and default durations.
package traffic_pkg;

   localparam logic [2:0] ST_ALLRED_BA = 3'd0;
   localparam logic [2:0] ST_GREEN_A   = 3'd1;
   localparam logic [2:0] ST_YELLOW_A  = 3'd2;
   localparam logic [2:0] ST_ALLRED_AB = 3'd3;
   localparam logic [2:0] ST_GREEN_B   = 3'd4;
   localparam logic [2:0] ST_YELLOW_B  = 3'd5;

   localparam int GREEN_CYC_D  = 40;
   localparam int MIN_GREEN_D  = 10;
   localparam int YELLOW_CYC_D = 10;
   localparam int ALLRED_CYC_D = 2;
   localparam int WALK_CYC_D   = 8;
   localparam int CW_D         = 6;

   typedef struct packed {
      logic g_a;
      logic y_a;
      logic r_a;
      logic g_b;
      logic y_b;
      logic r_b;
   } lamps_t;

   localparam lamps_t LAMP_GREEN_A  = lamps_t'(6'b100_001);
   localparam lamps_t LAMP_YELLOW_A = lamps_t'(6'b010_001);
   localparam lamps_t LAMP_ALLRED   = lamps_t'(6'b001_001);
   localparam lamps_t LAMP_GREEN_B  = lamps_t'(6'b001_100);
   localparam lamps_t LAMP_YELLOW_B = lamps_t'(6'b001_010);

endpackage

// File: rtl/traffic_phase_scheduler_timer.sv
// Loadable down-counter used as the per-phase timer.
// Load beats hold; hold beats decrement.
module phase_timer #(
   parameter int CW      = 6,
   parameter int RST_VAL = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_load,
   input  logic [CW-1:0] i_val,
   input  logic          i_hold,
   output logic [CW-1:0] o_count,
   output logic          o_zero
);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset)
         r_count <= CW'(RST_VAL);
      else if (i_load)
         r_count <= i_val;
      else if (!i_hold)
         r_count <= r_count - CW'(1);
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road phase scheduler with gap-out, latched pedestrian
// walks and emergency preemption; lamps decode the state register.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int GREEN_CYC  = GREEN_CYC_D,
   parameter int MIN_GREEN  = MIN_GREEN_D,
   parameter int YELLOW_CYC = YELLOW_CYC_D,
   parameter int ALLRED_CYC = ALLRED_CYC_D,
   parameter int WALK_CYC   = WALK_CYC_D,
   parameter int CW         = CW_D
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       car_a,
   input  logic       car_b,
   input  logic       ped_a,
   input  logic       ped_b,
   input  logic       emerg_req,
   input  logic       emerg_dir,
   output logic       green_a,
   output logic       yellow_a,
   output logic       red_a,
   output logic       green_b,
   output logic       yellow_b,
   output logic       red_b,
   output logic       walk_a,
   output logic       walk_b,
   output logic [2:0] phase
);

   localparam logic [CW-1:0] T_GREEN  = CW'(GREEN_CYC - 1);
   localparam logic [CW-1:0] T_YELLOW = CW'(YELLOW_CYC - 1);
   localparam logic [CW-1:0] T_ALLRED = CW'(ALLRED_CYC - 1);
   localparam logic [CW-1:0] T_GAP    = CW'(GREEN_CYC - MIN_GREEN);
   localparam logic [CW-1:0] T_WALK   = CW'(GREEN_CYC - WALK_CYC);

   logic [2:0]    r_state;
   logic [2:0]    w_next;
   logic [CW-1:0] w_timer;
   logic [CW-1:0] w_tmr_val;
   logic          w_tmr_zero;
   logic          w_tmr_load;
   logic          w_tmr_hold;
   logic          r_lat_a;
   logic          r_lat_b;
   logic          r_walk_a;
   logic          r_walk_b;
   lamps_t        w_lamps;

   logic w_emg_a;
   logic w_emg_b;
   logic w_gap_a;
   logic w_gap_b;
   logic w_chg;
   logic w_hold_grn;
   logic w_serve_a;
   logic w_serve_b;
   logic [2:0] w_emg_grn;

   assign w_emg_a   = emerg_req & ~emerg_dir;
   assign w_emg_b   = emerg_req &  emerg_dir;
   assign w_emg_grn = emerg_dir ? ST_GREEN_B : ST_GREEN_A;

   // elapsed >= MIN_GREEN-1 is the same as timer <= GREEN_CYC-MIN_GREEN
   assign w_gap_a = (w_timer <= T_GAP) & ~car_a & car_b
                  & ~r_walk_a & ~emerg_req;
   assign w_gap_b = (w_timer <= T_GAP) & ~car_b & car_a
                  & ~r_walk_b & ~emerg_req;

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= ST_ALLRED_BA;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_ALLRED_BA:
            if (w_tmr_zero)
               w_next = emerg_req ? w_emg_grn : ST_GREEN_A;
         ST_GREEN_A:
            if (w_emg_b || (!emerg_req && (w_tmr_zero || w_gap_a)))
               w_next = ST_YELLOW_A;
         ST_YELLOW_A:
            if (w_tmr_zero)
               w_next = ST_ALLRED_AB;
         ST_ALLRED_AB:
            if (w_tmr_zero)
               w_next = emerg_req ? w_emg_grn : ST_GREEN_B;
         ST_GREEN_B:
            if (w_emg_a || (!emerg_req && (w_tmr_zero || w_gap_b)))
               w_next = ST_YELLOW_B;
         ST_YELLOW_B:
            if (w_tmr_zero)
               w_next = ST_ALLRED_BA;
         default:
            w_next = ST_ALLRED_BA;
      endcase
   end

   always_comb begin
      w_lamps = LAMP_ALLRED;
      unique case (r_state)
         ST_GREEN_A:  w_lamps = LAMP_GREEN_A;
         ST_YELLOW_A: w_lamps = LAMP_YELLOW_A;
         ST_GREEN_B:  w_lamps = LAMP_GREEN_B;
         ST_YELLOW_B: w_lamps = LAMP_YELLOW_B;
         default:     w_lamps = LAMP_ALLRED;
      endcase
   end

   assign green_a  = w_lamps.g_a;
   assign yellow_a = w_lamps.y_a;
   assign red_a    = w_lamps.r_a;
   assign green_b  = w_lamps.g_b;
   assign yellow_b = w_lamps.y_b;
   assign red_b    = w_lamps.r_b;
   assign walk_a   = r_walk_a;
   assign walk_b   = r_walk_b;
   assign phase    = r_state;

   assign w_chg = (w_next != r_state);

   // preempted green keeps reloading so release starts a full green
   assign w_hold_grn = (r_state == ST_GREEN_A && w_emg_a)
                     | (r_state == ST_GREEN_B && w_emg_b);

   assign w_tmr_load = w_chg | (w_hold_grn & (w_timer != T_GREEN));
   assign w_tmr_hold = w_hold_grn;

   always_comb begin
      w_tmr_val = T_ALLRED;
      unique case (w_next)
         ST_GREEN_A, ST_GREEN_B:   w_tmr_val = T_GREEN;
         ST_YELLOW_A, ST_YELLOW_B: w_tmr_val = T_YELLOW;
         default:                  w_tmr_val = T_ALLRED;
      endcase
   end

   phase_timer #(
      .CW      (CW),
      .RST_VAL (ALLRED_CYC - 1)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_tmr_load),
      .i_val   (w_tmr_val),
      .i_hold  (w_tmr_hold),
      .o_count (w_timer),
      .o_zero  (w_tmr_zero)
   );

   // a walk is granted only on green entry, never mid-green
   assign w_serve_a = w_chg & (w_next == ST_GREEN_A)
                    & (r_lat_a | ped_a) & ~emerg_req;
   assign w_serve_b = w_chg & (w_next == ST_GREEN_B)
                    & (r_lat_b | ped_b) & ~emerg_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_lat_a <= 1'b0;
         r_lat_b <= 1'b0;
      end else begin
         if (w_serve_a)
            r_lat_a <= 1'b0;
         else if (ped_a)
            r_lat_a <= 1'b1;
         if (w_serve_b)
            r_lat_b <= 1'b0;
         else if (ped_b)
            r_lat_b <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_walk_a <= 1'b0;
         r_walk_b <= 1'b0;
      end else begin
         if (emerg_req)
            r_walk_a <= 1'b0;
         else if (w_serve_a)
            r_walk_a <= 1'b1;
         else if (w_chg || w_timer == T_WALK)
            r_walk_a <= 1'b0;
         if (emerg_req)
            r_walk_b <= 1'b0;
         else if (w_serve_b)
            r_walk_b <= 1'b1;
         else if (w_chg || w_timer == T_WALK)
            r_walk_b <= 1'b0;
      end
   end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: run-length
// vector table plus a hand-written preemption sequence.
module tb_traffic_phase_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       car_a = 1'b0;
   logic       car_b = 1'b0;
   logic       ped_a = 1'b0;
   logic       ped_b = 1'b0;
   logic       emerg_req = 1'b0;
   logic       emerg_dir = 1'b0;
   logic       green_a, yellow_a, red_a;
   logic       green_b, yellow_b, red_b;
   logic       walk_a, walk_b;
   logic [2:0] phase;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   traffic_phase_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .car_a     (car_a),
      .car_b     (car_b),
      .ped_a     (ped_a),
      .ped_b     (ped_b),
      .emerg_req (emerg_req),
      .emerg_dir (emerg_dir),
      .green_a   (green_a),
      .yellow_a  (yellow_a),
      .red_a     (red_a),
      .green_b   (green_b),
      .yellow_b  (yellow_b),
      .red_b     (red_b),
      .walk_a    (walk_a),
      .walk_b    (walk_b),
      .phase     (phase)
   );

   typedef struct {
      logic       rst;
      logic       ca;
      logic       cb;
      logic       pa;
      logic       pb;
      logic       em;
      logic       ed;
      int         n;
      logic [2:0] ph;
      logic       wa;
      logic       wb;
   } vec_t;

   vec_t tbl[$];

   // {gA,yA,rA,gB,yB,rB} expected for each phase
   function automatic logic [5:0] lamp_of(input logic [2:0] ph);
      case (ph)
         3'd1:    return 6'b100_001;
         3'd2:    return 6'b010_001;
         3'd4:    return 6'b001_100;
         3'd5:    return 6'b001_010;
         default: return 6'b001_001;
      endcase
   endfunction

   task automatic add(input logic rst, input logic ca,
                      input logic cb, input logic pa,
                      input logic pb, input logic em,
                      input logic ed, input int n,
                      input logic [2:0] ph, input logic wa,
                      input logic wb);
      vec_t v;
      v.rst = rst; v.ca = ca; v.cb = cb;
      v.pa = pa; v.pb = pb; v.em = em; v.ed = ed;
      v.n = n; v.ph = ph; v.wa = wa; v.wb = wb;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [2:0] ph,
                      input logic wa, input logic wb);
      logic [10:0] got;
      logic [10:0] want;
      got = {phase, green_a, yellow_a, red_a,
             green_b, yellow_b, red_b, walk_a, walk_b};
      want = {ph, lamp_of(ph), wa, wb};
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%b want=%b (phase|lamps|walks)",
                  nm, got, want);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic rst_both(input logic ca, input logic cb);
      add(1, ca, cb, 0, 0, 0, 0, 1, 0, 0, 0);
   endtask

   initial begin
      // default full cycle
      rst_both(1, 1);
      add(0, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 40, 1, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 10, 2, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0,  2, 3, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 40, 4, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 10, 5, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0,  2, 0, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 40, 1, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0,  1, 2, 0, 0);
      // gap-out on A after exactly MIN_GREEN
      rst_both(0, 1);
      add(0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 10, 1, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 10, 2, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0,  2, 3, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0,  5, 4, 0, 0);
      // no waiting car: full green; late gap-out on B
      rst_both(0, 0);
      add(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 40, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 10, 2, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0,  2, 3, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 20, 4, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 10, 5, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0,  2, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0,  3, 1, 0, 0);
      // ped_b latched in GREEN_A, re-latched during walk_b
      rst_both(1, 1);
      add(0, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0,  5, 1, 0, 0);
      add(0, 1, 1, 0, 1, 0, 0,  1, 1, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 34, 1, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 10, 2, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0,  2, 3, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0,  3, 4, 0, 1);
      add(0, 1, 1, 0, 1, 0, 0,  1, 4, 0, 1);
      add(0, 1, 1, 0, 0, 0, 0,  4, 4, 0, 1);
      add(0, 1, 1, 0, 0, 0, 0, 32, 4, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 10, 5, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0,  2, 0, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 40, 1, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 10, 2, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0,  2, 3, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0,  8, 4, 0, 1);
      add(0, 1, 1, 0, 0, 0, 0,  2, 4, 0, 0);
      // ped_a on entry cycle plus gap-out conditions
      rst_both(0, 1);
      add(0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0);
      add(0, 0, 1, 1, 0, 0, 0,  1, 1, 1, 0);
      add(0, 0, 1, 0, 0, 0, 0,  7, 1, 1, 0);
      add(0, 0, 1, 0, 0, 0, 0,  2, 1, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 10, 2, 0, 0);
      // preempt toward B from GREEN_A cycle 5
      rst_both(1, 1);
      add(0, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0,  5, 1, 0, 0);
      add(0, 1, 1, 0, 0, 1, 1, 10, 2, 0, 0);
      add(0, 1, 1, 0, 0, 1, 1,  2, 3, 0, 0);
      add(0, 1, 1, 0, 0, 1, 1, 50, 4, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 39, 4, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 10, 5, 0, 0);
      // preempt toward A during YELLOW_B, ped_a latched
      rst_both(0, 1);
      add(0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 10, 1, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 10, 2, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0,  2, 3, 0, 0);
      add(0, 1, 0, 1, 0, 0, 0,  1, 4, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0,  9, 4, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0,  3, 5, 0, 0);
      add(0, 1, 0, 0, 0, 1, 0,  7, 5, 0, 0);
      add(0, 1, 0, 0, 0, 1, 0,  2, 0, 0, 0);
      add(0, 1, 0, 0, 0, 1, 0, 30, 1, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 39, 1, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0,  1, 2, 0, 0);
      // walk cut by preemption is not reissued
      rst_both(1, 1);
      add(0, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0);
      add(0, 1, 1, 1, 0, 0, 0,  1, 1, 1, 0);
      add(0, 1, 1, 0, 0, 0, 0,  3, 1, 1, 0);
      add(0, 1, 1, 0, 0, 1, 0,  4, 1, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0,  5, 1, 0, 0);
      // reset mid GREEN_B discards latched ped_a
      rst_both(0, 1);
      add(0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 10, 1, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 10, 2, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0,  2, 3, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0,  5, 4, 0, 0);
      add(0, 1, 1, 1, 0, 0, 0,  1, 4, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 14, 4, 0, 0);
      add(1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 10, 1, 0, 0);

      #2;
      foreach (tbl[i]) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            reset     = tbl[i].rst;
            car_a     = tbl[i].ca;
            car_b     = tbl[i].cb;
            ped_a     = tbl[i].pa;
            ped_b     = tbl[i].pb;
            emerg_req = tbl[i].em;
            emerg_dir = tbl[i].ed;
            tick();
            chk($sformatf("vec%0d.%0d", i, k),
                tbl[i].ph, tbl[i].wa, tbl[i].wb);
         end
      end

      // held GREEN_A beats gap-out; direction flip exits
      reset = 1'b1;
      ped_a = 1'b0;
      ped_b = 1'b0;
      emerg_req = 1'b0;
      tick();
      chk("hs_reset", 3'd0, 0, 0);
      reset = 1'b0;
      car_a = 1'b0;
      car_b = 1'b1;
      emerg_req = 1'b1;
      emerg_dir = 1'b0;
      tick();
      chk("hs_allred", 3'd0, 0, 0);
      tick();
      chk("hs_enter_a", 3'd1, 0, 0);
      for (int k = 0; k < 20; k++) begin
         tick();
         chk($sformatf("hs_hold_a%0d", k), 3'd1, 0, 0);
      end
      emerg_dir = 1'b1;
      tick();
      chk("hs_flip", 3'd2, 0, 0);
      for (int k = 0; k < 9; k++) begin
         tick();
         chk($sformatf("hs_ya%0d", k), 3'd2, 0, 0);
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         chk($sformatf("hs_ar%0d", k), 3'd3, 0, 0);
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("hs_gb%0d", k), 3'd4, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
